// File: rtl/sram_port_arbiter.sv
// Single-port RA1SHD 512x8 arbiter for IO loader, CPU fetch and CPU data ports.
// Define SRAM_ARB_RR_EN for round-robin I/D arbitration (default: fixed I > D).
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IO_REQ,
  input  logic                  IO_WE,
  input  logic [ADDR_WIDTH-1:0] IO_A,
  input  logic [DATA_WIDTH-1:0] IO_D,
  input  logic                  IO_LOCK,
  output logic                  IO_GNT,
  output logic                  IO_RVALID,
  input  logic                  I_REQ,
  input  logic [ADDR_WIDTH-1:0] I_A,
  output logic                  I_GNT,
  output logic                  I_RVALID,
  input  logic                  D_REQ,
  input  logic                  D_WE,
  input  logic [ADDR_WIDTH-1:0] D_A,
  input  logic [DATA_WIDTH-1:0] D_D,
  output logic                  D_GNT,
  output logic                  D_RVALID,
  output logic                  CPU_HOLD,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  SRAM_CEN,
  output logic                  SRAM_WEN,
  output logic [ADDR_WIDTH-1:0] SRAM_A,
  output logic [DATA_WIDTH-1:0] SRAM_D,
  input  logic [DATA_WIDTH-1:0] SRAM_Q
);

  typedef enum logic [1:0] {IDLE, ACCESS, LOCKED} state_t;

  state_t                state_q, state_d;
  logic                  io_gnt_q, io_gnt_d;
  logic                  i_gnt_q, i_gnt_d;
  logic                  d_gnt_q, d_gnt_d;
  logic                  io_rv_q, io_rv_d;
  logic                  i_rv_q, i_rv_d;
  logic                  d_rv_q, d_rv_d;
  logic                  cen_q, cen_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic                  io_elig, i_elig, d_elig;
  logic                  pick_io, pick_i, pick_d;
`ifdef SRAM_ARB_RR_EN
  logic                  rr_q, rr_d;
`endif

  // A port granted this cycle sits out the next edge; lock removes the CPU ports
  always_comb begin
    io_elig = IO_REQ && !io_gnt_q;
    i_elig  = I_REQ && !i_gnt_q && !IO_LOCK;
    d_elig  = D_REQ && !d_gnt_q && !IO_LOCK;
    pick_io = io_elig;
`ifdef SRAM_ARB_RR_EN
    pick_i  = !io_elig && i_elig && (!d_elig || !rr_q);
    pick_d  = !io_elig && d_elig && (!i_elig || rr_q);
    rr_d    = rr_q;
    if (pick_i) rr_d = 1'b1;
    else if (pick_d) rr_d = 1'b0;
`else
    pick_i  = !io_elig && i_elig;
    pick_d  = !io_elig && !i_elig && d_elig;
`endif
  end

  always_comb begin
    io_gnt_d = pick_io;
    i_gnt_d  = pick_i;
    d_gnt_d  = pick_d;
    // Read tags: wen_q still holds the polarity of the access now in the macro
    io_rv_d  = io_gnt_q && wen_q;
    i_rv_d   = i_gnt_q;
    d_rv_d   = d_gnt_q && wen_q;
    cen_d    = !(pick_io || pick_i || pick_d);
    wen_d    = 1'b1;
    a_d      = a_q;
    wd_d     = wd_q;
    if (pick_io) begin
      wen_d = !IO_WE;
      a_d   = IO_A;
      wd_d  = IO_D;
    end else if (pick_i) begin
      a_d   = I_A;
    end else if (pick_d) begin
      wen_d = !D_WE;
      a_d   = D_A;
      wd_d  = D_D;
    end
    if (IO_LOCK) state_d = LOCKED;
    else if (!cen_d) state_d = ACCESS;
    else state_d = IDLE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      io_gnt_q <= 1'b0;
      i_gnt_q  <= 1'b0;
      d_gnt_q  <= 1'b0;
      io_rv_q  <= 1'b0;
      i_rv_q   <= 1'b0;
      d_rv_q   <= 1'b0;
      cen_q    <= 1'b1;
      wen_q    <= 1'b1;
      a_q      <= '0;
      wd_q     <= '0;
`ifdef SRAM_ARB_RR_EN
      rr_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      io_gnt_q <= io_gnt_d;
      i_gnt_q  <= i_gnt_d;
      d_gnt_q  <= d_gnt_d;
      io_rv_q  <= io_rv_d;
      i_rv_q   <= i_rv_d;
      d_rv_q   <= d_rv_d;
      cen_q    <= cen_d;
      wen_q    <= wen_d;
      a_q      <= a_d;
      wd_q     <= wd_d;
`ifdef SRAM_ARB_RR_EN
      rr_q     <= rr_d;
`endif
    end
  end

  assign IO_GNT    = io_gnt_q;
  assign I_GNT     = i_gnt_q;
  assign D_GNT     = d_gnt_q;
  assign IO_RVALID = io_rv_q;
  assign I_RVALID  = i_rv_q;
  assign D_RVALID  = d_rv_q;
  assign CPU_HOLD  = (state_q == LOCKED);
  assign SRAM_CEN  = cen_q;
  assign SRAM_WEN  = wen_q;
  assign SRAM_A    = a_q;
  assign SRAM_D    = wd_q;
  assign RDATA     = SRAM_Q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a behavioural RA1SHD macro model.
// Expected grant order adapts to SRAM_ARB_RR_EN.
module tb_sram_port_arbiter;

  logic       CLK, RST;
  logic       IO_REQ, IO_WE, IO_LOCK, IO_GNT, IO_RVALID;
  logic [8:0] IO_A;
  logic [7:0] IO_D;
  logic       I_REQ, I_GNT, I_RVALID;
  logic [8:0] I_A;
  logic       D_REQ, D_WE, D_GNT, D_RVALID;
  logic [8:0] D_A;
  logic [7:0] D_D;
  logic       CPU_HOLD;
  logic [7:0] RDATA;
  logic       SRAM_CEN, SRAM_WEN;
  logic [8:0] SRAM_A;
  logic [7:0] SRAM_D, SRAM_Q;

  typedef struct {
    int         port;
    logic       we;
    logic [8:0] addr;
    logic [7:0] data;
  } gnt_t;

  typedef struct {
    int         port;
    logic [7:0] data;
  } rd_t;

  gnt_t exp_gnt[$];
  rd_t  exp_rd[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [7:0] mem [0:511];

  sram_port_arbiter #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST),
    .IO_REQ(IO_REQ), .IO_WE(IO_WE), .IO_A(IO_A), .IO_D(IO_D), .IO_LOCK(IO_LOCK),
    .IO_GNT(IO_GNT), .IO_RVALID(IO_RVALID),
    .I_REQ(I_REQ), .I_A(I_A), .I_GNT(I_GNT), .I_RVALID(I_RVALID),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_A(D_A), .D_D(D_D), .D_GNT(D_GNT), .D_RVALID(D_RVALID),
    .CPU_HOLD(CPU_HOLD), .RDATA(RDATA),
    .SRAM_CEN(SRAM_CEN), .SRAM_WEN(SRAM_WEN), .SRAM_A(SRAM_A), .SRAM_D(SRAM_D),
    .SRAM_Q(SRAM_Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous single-port macro: write or read on each enabled edge
  always @(posedge CLK) begin
    if (!SRAM_CEN) begin
      if (!SRAM_WEN) mem[SRAM_A] <= SRAM_D;
      else SRAM_Q <= mem[SRAM_A];
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int port_of(input logic [2:0] v);
    if (v == 3'b100) return 0;
    if (v == 3'b010) return 1;
    if (v == 3'b001) return 2;
    return -1;
  endfunction

  task automatic push_gnt(input int port, input logic we, input logic [8:0] addr, input logic [7:0] data);
    gnt_t g;
    g.port = port; g.we = we; g.addr = addr; g.data = data;
    exp_gnt.push_back(g);
  endtask

  task automatic push_rd(input int port, input logic [7:0] data);
    rd_t r;
    r.port = port; r.data = data;
    exp_rd.push_back(r);
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows a grant or read result
  always @(negedge CLK) begin
    logic [2:0] gv, rv;
    gnt_t g;
    rd_t  r;
    if (!RST) begin
      gv = {IO_GNT, I_GNT, D_GNT};
      rv = {IO_RVALID, I_RVALID, D_RVALID};
      if (gv != 3'b000) begin
        if (exp_gnt.size() == 0) begin
          check_output("unexpected_gnt", {29'd0, gv}, 32'd0);
        end else begin
          g = exp_gnt.pop_front();
          check_output("gnt_port", port_of(gv), g.port);
          check_output("gnt_cen", SRAM_CEN, 0);
          check_output("gnt_wen", SRAM_WEN, {31'd0, !g.we});
          check_output("gnt_addr", SRAM_A, g.addr);
          if (g.we) check_output("gnt_wdata", SRAM_D, g.data);
        end
      end else begin
        check_output("idle_cen", SRAM_CEN, 1);
      end
      if (rv != 3'b000) begin
        if (exp_rd.size() == 0) begin
          check_output("unexpected_rvalid", {29'd0, rv}, 32'd0);
        end else begin
          r = exp_rd.pop_front();
          check_output("rvalid_port", port_of(rv), r.port);
          check_output("rdata", RDATA, r.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic io_access(input logic we, input logic [8:0] a, input logic [7:0] d);
    bit got = 0;
    IO_REQ = 1'b1; IO_WE = we; IO_A = a; IO_D = d;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (IO_GNT) got = 1;
    end
    IO_REQ = 1'b0;
    if (!got) check_output("io_gnt_timeout", 0, 1);
  endtask

  task automatic apply_stimulus();
    int  ic, dc;
    bit  got;
    // Reset values
    RST = 1'b0;
    IO_REQ = 0; IO_WE = 0; IO_A = 0; IO_D = 0; IO_LOCK = 0;
    I_REQ = 0; I_A = 0; D_REQ = 0; D_WE = 0; D_A = 0; D_D = 0;
    #1 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_output("rst_cen", SRAM_CEN, 1);
    check_output("rst_wen", SRAM_WEN, 1);
    check_output("rst_addr", SRAM_A, 0);
    check_output("rst_wdata", SRAM_D, 0);
    check_output("rst_gnts", {IO_GNT, I_GNT, D_GNT}, 0);
    check_output("rst_rvalids", {IO_RVALID, I_RVALID, D_RVALID}, 0);
    check_output("rst_hold", CPU_HOLD, 0);
    RST = 1'b0;
    tick();

    // IO write, IO read-back, then preload fetch/data locations
    push_gnt(0, 1, 9'h020, 8'h3C);
    io_access(1, 9'h020, 8'h3C);
    push_gnt(0, 0, 9'h020, 8'h00);
    push_rd(0, 8'h3C);
    io_access(0, 9'h020, 8'h00);
    push_gnt(0, 1, 9'h021, 8'hA5);
    io_access(1, 9'h021, 8'hA5);
    push_gnt(0, 1, 9'h002, 8'h5A);
    io_access(1, 9'h002, 8'h5A);
    repeat (3) tick();

    // I and D contend; IO cuts in after I's third grant
    push_gnt(1, 0, 9'h021, 0); push_rd(1, 8'hA5);
    push_gnt(2, 0, 9'h002, 0); push_rd(2, 8'h5A);
    push_gnt(1, 0, 9'h021, 0); push_rd(1, 8'hA5);
    push_gnt(2, 0, 9'h002, 0); push_rd(2, 8'h5A);
    push_gnt(1, 0, 9'h021, 0); push_rd(1, 8'hA5);
    push_gnt(0, 1, 9'h030, 8'h77);
`ifdef SRAM_ARB_RR_EN
    push_gnt(2, 0, 9'h002, 0); push_rd(2, 8'h5A);
    push_gnt(1, 0, 9'h021, 0); push_rd(1, 8'hA5);
`else
    push_gnt(1, 0, 9'h021, 0); push_rd(1, 8'hA5);
    push_gnt(2, 0, 9'h002, 0); push_rd(2, 8'h5A);
`endif
    I_REQ = 1; I_A = 9'h021;
    D_REQ = 1; D_WE = 0; D_A = 9'h002;
    ic = 0; dc = 0;
    for (int c = 0; c < 40 && (I_REQ || D_REQ || IO_REQ); c++) begin
      tick();
      if (IO_GNT) IO_REQ = 0;
      if (I_GNT) begin
        ic++;
        if (ic == 3) begin
          IO_REQ = 1; IO_WE = 1; IO_A = 9'h030; IO_D = 8'h77;
        end
        if (ic == 4) I_REQ = 0;
      end
      if (D_GNT) begin
        dc++;
        if (dc == 3) D_REQ = 0;
      end
    end
    check_output("contend_i_count", ic, 4);
    check_output("contend_d_count", dc, 3);
    I_REQ = 0; D_REQ = 0; IO_REQ = 0;
    repeat (3) tick();

    // Lock raised while a D read is in flight
    push_gnt(2, 0, 9'h002, 0); push_rd(2, 8'h5A);
    D_REQ = 1; D_WE = 0; D_A = 9'h002;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (D_GNT) got = 1;
    end
    check_output("lock_d_gnt", got, 1);
    D_REQ = 0;
    IO_LOCK = 1;
    I_REQ = 1; I_A = 9'h021;
    tick();
    check_output("lock_hold_set", CPU_HOLD, 1);
    push_gnt(0, 0, 9'h030, 0); push_rd(0, 8'h77);
    io_access(0, 9'h030, 8'h00);
    repeat (3) tick();
    check_output("lock_hold_kept", CPU_HOLD, 1);
    push_gnt(1, 0, 9'h021, 0); push_rd(1, 8'hA5);
    IO_LOCK = 0;
    tick();
    check_output("unlock_hold_clr", CPU_HOLD, 0);
    got = I_GNT;
    if (!got) begin
      tick();
      got = I_GNT;
    end
    check_output("unlock_i_gnt", got, 1);
    I_REQ = 0;
    repeat (3) tick();

    // Reset pulse during an I grant cycle discards the pending read
    I_REQ = 1; I_A = 9'h021;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (I_GNT) got = 1;
    end
    check_output("rst_mid_i_gnt", got, 1);
    #1 RST = 1'b1;
    #1;
    check_output("rst_mid_cen", SRAM_CEN, 1);
    check_output("rst_mid_gnts", {IO_GNT, I_GNT, D_GNT}, 0);
    I_REQ = 0;
    #1 RST = 1'b0;
    tick();
    check_output("rst_mid_no_rvalid", I_RVALID, 0);
    check_output("rst_mid_gnts_after", {IO_GNT, I_GNT, D_GNT}, 0);
    repeat (3) tick();
  endtask

  initial begin
    apply_stimulus();
    check_output("gnt_queue_empty", exp_gnt.size(), 0);
    check_output("rd_queue_empty", exp_rd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Single-port arbiter for the RA1SHD 512x8 SRAM. It shares the macro between three requesters: the serial loader (SRAM_IO_CTRL, "IO"), the CPU instruction fetch ("I") and the CPU data port ("D"). It issues one registered SRAM access per cycle and returns read data with fixed latency. A lock mode gives IO exclusive ownership during program load and holds the CPU off.

Parameters:
ADDR_WIDTH, 9, SRAM address bits
DATA_WIDTH, 8, SRAM data bits

Ports:
CLK  in  1  clock; all state on rising edge
RST  in  1  asynchronous, active-high reset
IO_REQ  in  1  IO access request
IO_WE  in  1  1=write, 0=read
IO_A  in  ADDR_WIDTH  IO address
IO_D  in  DATA_WIDTH  IO write data
IO_LOCK  in  1  request exclusive SRAM ownership for IO
IO_GNT  out  1  IO request issued this cycle
IO_RVALID  out  1  RDATA holds IO read result
I_REQ  in  1  instruction fetch request (read-only)
I_A  in  ADDR_WIDTH  fetch address
I_GNT  out  1  fetch issued this cycle
I_RVALID  out  1  RDATA holds fetch result
D_REQ  in  1  CPU data request
D_WE  in  1  1=write, 0=read
D_A  in  ADDR_WIDTH  data address
D_D  in  DATA_WIDTH  data write value
D_GNT  out  1  data request issued this cycle
D_RVALID  out  1  RDATA holds data read result
CPU_HOLD  out  1  CPU must stall; IO owns SRAM
RDATA  out  DATA_WIDTH  SRAM_Q pass-through
SRAM_CEN  out  1  macro chip enable, active low
SRAM_WEN  out  1  macro write enable, active low
SRAM_A  out  ADDR_WIDTH  macro address
SRAM_D  out  DATA_WIDTH  macro write data
SRAM_Q  in  DATA_WIDTH  macro read data

Behaviour:
- Reset values: SRAM_CEN=1, SRAM_WEN=1, SRAM_A=0, SRAM_D=0; all *_GNT=0, all *_RVALID=0, CPU_HOLD=0; FSM=IDLE; RR pointer = I.
- FSM states:
  - IDLE: no access driven.
  - ACCESS: one access driven this cycle.
  - LOCKED: IO exclusive; may also drive an access.
- Arbitration at every edge, over eligible requests:
  - A requester whose GNT is 1 in the current cycle is masked for that edge. Consequence: each requester gets at most one grant per two cycles; different requesters may be granted back-to-back.
  - Priority: IO > I > D (I/D order changes only under the optional feature).
  - Winner's address, data and WE are registered onto the SRAM_* pins. Its GNT=1 for exactly that one cycle. SRAM_CEN=0; SRAM_WEN=!WE.
  - Next state is ACCESS, or LOCKED if the lock is active.
  - No eligible request: SRAM_CEN=1, SRAM_WEN=1, A/D hold their last value, state IDLE.
- Requester rule: REQ/A/WE/D are held stable until GNT is observed. A requester must deassert REQ or present its next request at the edge that ends its GNT cycle.
- Read latency: request sampled at edge E0, GNT high during E0..E1, macro captures at E1. The matching *_RVALID is high for one cycle, E1..E2, with RDATA=SRAM_Q. Writes produce no RVALID.
- RVALID tags are registered copies of the granted read port; at most one RVALID is high per cycle.
- Lock:
  - IO_LOCK=1 sampled at an edge → LOCKED from that edge; CPU_HOLD=1 registered; I/D are ineligible.
  - A read already granted to I/D still returns its RVALID.
  - IO_LOCK=0 sampled → exit to IDLE/ACCESS; CPU_HOLD=0 from that edge.
- Simultaneous IO_LOCK rise and I/D request at the same edge: lock wins, CPU not granted.
- RST asserted mid-access: all outputs go to reset values immediately and any pending RVALID is discarded.
- Address values are passed unmodified; no wrap or offset is applied.

Optional Feature:
SRAM_ARB_RR_EN:
- Defined: I and D are arbitrated round-robin. A 1-bit pointer names the favoured CPU port and flips to the other port after each I or D grant. IO remains the highest priority and does not move the pointer.
- Undefined: fixed I > D; pointer logic is absent.

Test Plan:
- Reset, then IO write: IO_REQ=1, IO_WE=1, IO_A=0x020, IO_D=0x3C → IO_GNT one cycle, SRAM_CEN=0, SRAM_WEN=0, SRAM_A=0x020, SRAM_D=0x3C; no RVALID.
- IO read of 0x020 after that write → IO_GNT, then next cycle IO_RVALID=1 with RDATA=0x3C.
- I_REQ and D_REQ both held (I_A=0x021, D_A=0x002, reads), macro undefined → I, D, I, D grants on alternate cycles; I_RVALID/D_RVALID each one cycle after the matching GNT.
- Same stimulus with SRAM_ARB_RR_EN, plus IO_REQ raised at the edge of D's turn → IO granted first; I/D alternation resumes with D next; pointer unchanged by IO.
- IO_LOCK=1 while D read of 0x002 is granted → D_RVALID still returned; CPU_HOLD=1 next cycle; I_REQ held and never granted; IO_LOCK=0 → CPU_HOLD=0 and I granted within 2 cycles.
- RST pulse during I grant cycle → SRAM_CEN=1, I_RVALID never asserted, all GNT=0 until the next arbitration edge after release.
